// File: rtl/vliw_pkg.sv
// Shared types and sizes for the VLIW front end.
package vliw_pkg;

  localparam int BUNDLE_W         = 128;
  localparam int SLOT_W           = 32;
  localparam int SLOTS_PER_BUNDLE = 4;
  localparam int BUNDLE_BYTES     = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [BUNDLE_W-1:0] bundle;
  } bundle_entry_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Synchronous FIFO of fetched bundles; flush overrides push and pop.
module bundle_fifo
  import vliw_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  bundle_entry_t wdata,
  output logic          full,
  output logic          empty,
  output bundle_entry_t head,
  output logic [AW:0]   count
);

  bundle_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Full plus pop frees the head slot in the same edge, so a push is legal.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, IDLE/FETCH/HALTED control, bundle buffering.
module fetch_unit
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          INIT_WAIT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         mem_pc_out,
  input  logic [BUNDLE_W-1:0] mem_bundle_in,
  output logic                bundle_valid,
  input  logic                bundle_ready,
  output logic [BUNDLE_W-1:0] bundle_out,
  output logic [31:0]         bundle_pc,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                halt_req,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fetch_count;
  logic [31:0]   r_idle_cnt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  bundle_entry_t w_head;
  bundle_entry_t w_wdata;
  logic          w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];

  assign mem_pc_out   = r_fetch_pc;
  assign bundle_valid = (w_count != '0);
  assign bundle_out   = w_head.bundle;
  assign bundle_pc    = w_head.pc;
  assign halted       = (r_state == HALTED);
  assign fetch_count  = r_fetch_count;

  assign w_pop   = !w_empty && bundle_ready;
  assign w_push  = (r_state == FETCH) && !redirect_valid && !halt_req && (!w_full || w_pop);
  assign w_wdata = '{pc: r_fetch_pc, bundle: mem_bundle_in};

  // Redirect outranks everything: PC load here, FIFO flush via the flush port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_fetch_count <= '0;
      r_idle_cnt    <= '0;
    end else begin
      if (redirect_valid)  r_fetch_pc <= align_pc(redirect_pc);
      else if (w_push)     r_fetch_pc <= r_fetch_pc + 32'(BUNDLE_BYTES);
      if (w_push) r_fetch_count <= r_fetch_count + 32'd1;

      case (r_state)
        IDLE: begin
          if ((r_idle_cnt + 32'd1) >= 32'(INIT_WAIT)) r_state <= FETCH;
          else r_idle_cnt <= r_idle_cnt + 32'd1;
        end
        FETCH: begin
          if (halt_req) r_state <= HALTED;
        end
        HALTED: begin
          if (redirect_valid && !halt_req) r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bundle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: streaming, backpressure, redirect, halt, PC wrap.
module tb_fetch_unit;

  logic         clk;
  logic         rst_n;
  logic [31:0]  mem_pc_out;
  logic [127:0] mem_bundle_in;
  logic         bundle_valid;
  logic         bundle_ready;
  logic [127:0] bundle_out;
  logic [31:0]  bundle_pc;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         halt_req;
  logic         halted;
  logic [31:0]  fetch_count;

  logic         rst_n_w;
  logic [31:0]  mem_pc_out_w;
  logic [127:0] mem_bundle_in_w;
  logic         bundle_valid_w;
  logic         bundle_ready_w;
  logic [127:0] bundle_out_w;
  logic [31:0]  bundle_pc_w;
  logic         redirect_valid_w;
  logic [31:0]  redirect_pc_w;
  logic         halt_req_w;
  logic         halted_w;
  logic [31:0]  fetch_count_w;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] sb_pc;

  function automatic logic [127:0] mem_fn(input logic [31:0] pc);
    return {~pc, pc + 32'd4, pc + 32'd8, pc + 32'd12};
  endfunction

  assign mem_bundle_in   = mem_fn(mem_pc_out);
  assign mem_bundle_in_w = mem_fn(mem_pc_out_w);

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_pc_out(mem_pc_out), .mem_bundle_in(mem_bundle_in),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready), .bundle_out(bundle_out),
    .bundle_pc(bundle_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF0)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .mem_pc_out(mem_pc_out_w), .mem_bundle_in(mem_bundle_in_w),
    .bundle_valid(bundle_valid_w), .bundle_ready(bundle_ready_w), .bundle_out(bundle_out_w),
    .bundle_pc(bundle_pc_w), .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .halt_req(halt_req_w), .halted(halted_w), .fetch_count(fetch_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes completing at the next posedge are checked against the queue.
  always @(negedge clk) begin
    if (rst_n && bundle_valid && bundle_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h, required no bundle", bundle_pc);
      end else begin
        sb_pc = exp_q.pop_front();
        if (bundle_pc !== sb_pc || bundle_out !== mem_fn(sb_pc)) begin
          n_fail++;
          $display("FAIL sb_bundle: got pc=%h data=%h, required pc=%h data=%h",
                   bundle_pc, bundle_out, sb_pc, mem_fn(sb_pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    bundle_ready   = ready;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bundle_ready   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    tick(2);
    n_tests++;
    if (bundle_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b halted=%b, required 0 0", bundle_valid, halted);
    end
    n_tests++;
    if (fetch_count !== 32'd0 || mem_pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got cnt=%h pc=%h, required 0 0", fetch_count, mem_pc_out);
    end
    rst_n = 1'b1;
    tick(1);
    n_tests++;
    if (bundle_valid !== 1'b0 || mem_pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_no_push: got valid=%b pc=%h, required 0 0", bundle_valid, mem_pc_out);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k * 16));
    for (int k = 0; k < 6; k++) begin
      tick(1);
      n_tests++;
      if (bundle_valid !== 1'b1 || bundle_pc !== 32'(k * 16) || fetch_count !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b pc=%h cnt=%0d, required v=1 pc=%h cnt=%0d",
                 k, bundle_valid, bundle_pc, fetch_count, 32'(k * 16), k + 1);
      end
    end
    tick(1);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    tick(6);
    n_tests++;
    if (bundle_valid !== 1'b1 || bundle_pc !== 32'h00 || mem_pc_out !== 32'h20 || fetch_count !== 32'd2) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b head=%h pc=%h cnt=%0d, required 1 00 20 2",
               bundle_valid, bundle_pc, mem_pc_out, fetch_count);
    end
    bundle_ready = 1'b1;
    tick(1);
    n_tests++;
    if (bundle_valid !== 1'b1 || bundle_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume1: got v=%b head=%h, required 1 10", bundle_valid, bundle_pc);
    end
    tick(1);
    n_tests++;
    if (bundle_valid !== 1'b1 || bundle_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL bp_resume2: got v=%b head=%h, required 1 20", bundle_valid, bundle_pc);
    end
    tick(1);
    bundle_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || bundle_pc !== 32'h30 || fetch_count !== 32'd5) begin
      n_fail++;
      $display("FAIL bp_end: got left=%0d head=%h cnt=%0d, required 0 30 5",
               exp_q.size(), bundle_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick(1);
    redirect_valid = 1'b0;
    n_tests++;
    if (bundle_valid !== 1'b0 || mem_pc_out !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_flush: got v=%b pc=%h, required 0 100", bundle_valid, mem_pc_out);
    end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h120);
    tick(1);
    n_tests++;
    if (bundle_valid !== 1'b1 || bundle_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_target: got v=%b head=%h, required 1 100", bundle_valid, bundle_pc);
    end
    bundle_ready = 1'b1;
    tick(1);
    bundle_ready = 1'b0;
    n_tests++;
    if (bundle_pc !== 32'h110 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL redir_next: got head=%h left=%0d, required 110 2", bundle_pc, exp_q.size());
    end
    tick(1);
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    n_tests++;
    if (halted !== 1'b1 || mem_pc_out !== 32'h130 || bundle_pc !== 32'h110) begin
      n_fail++;
      $display("FAIL halt_enter: got h=%b pc=%h head=%h, required 1 130 110", halted, mem_pc_out, bundle_pc);
    end
    bundle_ready = 1'b1;
    tick(2);
    n_tests++;
    if (bundle_valid !== 1'b0 || halted !== 1'b1 || mem_pc_out !== 32'h130) begin
      n_fail++;
      $display("FAIL halt_drain: got v=%b h=%b pc=%h, required 0 1 130", bundle_valid, halted, mem_pc_out);
    end
    tick(2);
    n_tests++;
    if (mem_pc_out !== 32'h130 || fetch_count !== 32'd8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_frozen: got pc=%h cnt=%0d left=%0d, required 130 8 0",
               mem_pc_out, fetch_count, exp_q.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    exp_q.push_back(32'h40);
    tick(1);
    redirect_valid = 1'b0;
    n_tests++;
    if (halted !== 1'b0 || mem_pc_out !== 32'h40) begin
      n_fail++;
      $display("FAIL halt_resume: got h=%b pc=%h, required 0 40", halted, mem_pc_out);
    end
    tick(1);
    n_tests++;
    if (bundle_valid !== 1'b1 || bundle_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL resume_bundle: got v=%b head=%h, required 1 40", bundle_valid, bundle_pc);
    end
    tick(1);
    bundle_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL resume_drain: got %0d left, required 0", exp_q.size());
    end
    halt_req       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    tick(1);
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    n_tests++;
    if (halted !== 1'b1 || bundle_valid !== 1'b0 || mem_pc_out !== 32'h200) begin
      n_fail++;
      $display("FAIL halt_redir: got h=%b v=%b pc=%h, required 1 0 200", halted, bundle_valid, mem_pc_out);
    end
    tick(2);
    n_tests++;
    if (bundle_valid !== 1'b0 || fetch_count !== 32'd10) begin
      n_fail++;
      $display("FAIL halt_idle: got v=%b cnt=%0d, required 0 10", bundle_valid, fetch_count);
    end
  endtask

  task automatic test_wrap();
    n_tests++;
    if (mem_pc_out_w !== 32'hFFFF_FFF0 || bundle_valid_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: got pc=%h v=%b, required fffffff0 0", mem_pc_out_w, bundle_valid_w);
    end
    wq.push_back(32'hFFFF_FFF0);
    wq.push_back(32'h0000_0000);
    rst_n_w = 1'b1;
    tick(2);
    for (int k = 0; k < 2; k++) begin
      sb_pc = wq.pop_front();
      n_tests++;
      if (bundle_valid_w !== 1'b1 || bundle_pc_w !== sb_pc || bundle_out_w !== mem_fn(sb_pc)) begin
        n_fail++;
        $display("FAIL wrap_seq_%0d: got v=%b pc=%h, required 1 %h", k, bundle_valid_w, bundle_pc_w, sb_pc);
      end
      if (k == 0) tick(1);
    end
    n_tests++;
    if (fetch_count_w !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d, required 2", fetch_count_w);
    end
    rst_n_w = 1'b0;
    tick(1);
    n_tests++;
    if (bundle_valid_w !== 1'b0 || fetch_count_w !== 32'd0 || mem_pc_out_w !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL wrap_midreset: got v=%b cnt=%0d pc=%h, required 0 0 fffffff0",
               bundle_valid_w, fetch_count_w, mem_pc_out_w);
    end
  endtask

  initial begin
    rst_n_w          = 1'b0;
    bundle_ready_w   = 1'b1;
    redirect_valid_w = 1'b0;
    redirect_pc_w    = '0;
    halt_req_w       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
